// File: rtl/video_pkg.sv
// Shared video definitions: the raster timing bundle, the timing generator state
// encoding and the default 640x480@60 geometry.
package video_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    typedef struct packed {
        logic hsync_n;
        logic vsync_n;
        logic blank_n;
        logic end_of_line;
        logic end_of_frame;
    } VGA_Timing;

    localparam VGA_Timing TIMING_IDLE = '{
        hsync_n:      1'b1,
        vsync_n:      1'b1,
        blank_n:      1'b0,
        end_of_line:  1'b0,
        end_of_frame: 1'b0
    };

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } vga_state_e;

    // Counter increment that wraps back to zero after the last position.
    function automatic logic [9:0] wrap_inc(input logic [9:0] val, input logic [9:0] last);
        return (val == last) ? 10'd0 : (val + 10'd1);
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters, sync/blank decode and a line-fetch
// request one line ahead. Optional frame counter under VGA_TIMING_GEN_FRAME_CNT_EN.
module vga_timing_gen
    import video_pkg::VGA_Timing;
    import video_pkg::TIMING_IDLE;
    import video_pkg::vga_state_e;
    import video_pkg::ST_IDLE;
    import video_pkg::ST_RUN;
    import video_pkg::wrap_inc;
#(
    parameter int H_ACTIVE = video_pkg::H_ACTIVE,
    parameter int H_FP     = video_pkg::H_FP,
    parameter int H_SYNC   = video_pkg::H_SYNC,
    parameter int H_BP     = video_pkg::H_BP,
    parameter int V_ACTIVE = video_pkg::V_ACTIVE,
    parameter int V_FP     = video_pkg::V_FP,
    parameter int V_SYNC   = video_pkg::V_SYNC,
    parameter int V_BP     = video_pkg::V_BP
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    output VGA_Timing   timing_o,
    output logic [9:0]  x_o,
    output logic [9:0]  y_o,
    output logic        fetch_start_o,
    output logic [9:0]  fetch_line_o
`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt_o
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if ((H_TOTAL > 1024) || (V_TOTAL > 1024)) begin : g_width_chk
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end

    localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
    // Decode bounds are 11 bits so a 1024-wide field still compares correctly.
    localparam logic [10:0] H_VIS   = 11'(H_ACTIVE);
    localparam logic [10:0] H_SYN_S = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYN_E = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_VIS   = 11'(V_ACTIVE);
    localparam logic [10:0] V_SYN_S = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SYN_E = 11'(V_ACTIVE + V_FP + V_SYNC);

    vga_state_e  state_q, state_d;
    logic [9:0]  h_q, h_d;
    logic [9:0]  v_q, v_d;
    logic [9:0]  nxt_v_s;
    VGA_Timing   timing_q, timing_d;
    logic        fetch_start_q, fetch_start_d;
    logic [9:0]  fetch_line_q, fetch_line_d;

    // Next state, next raster position and the decode of that position.
    always_comb begin
        state_d       = state_q;
        h_d           = 10'd0;
        v_d           = 10'd0;
        nxt_v_s       = 10'd0;
        timing_d      = TIMING_IDLE;
        fetch_start_d = 1'b0;
        fetch_line_d  = fetch_line_q;

        case (state_q)
            ST_IDLE: begin
                if (en_i) state_d = ST_RUN;
                else      state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (en_i) state_d = ST_RUN;
                else      state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Entering RUN presents (0,0); only an ongoing RUN advances the raster.
        if (en_i && (state_q == ST_RUN)) begin
            if (h_q == H_LAST) begin
                h_d = 10'd0;
                v_d = wrap_inc(v_q, V_LAST);
            end else begin
                h_d = h_q + 10'd1;
                v_d = v_q;
            end
        end else begin
            h_d = 10'd0;
            v_d = 10'd0;
        end

        nxt_v_s = wrap_inc(v_d, V_LAST);

        if (state_d == ST_RUN) begin
            timing_d.blank_n      = ({1'b0, h_d} < H_VIS) && ({1'b0, v_d} < V_VIS);
            timing_d.hsync_n      = !(({1'b0, h_d} >= H_SYN_S) && ({1'b0, h_d} < H_SYN_E));
            timing_d.vsync_n      = !(({1'b0, v_d} >= V_SYN_S) && ({1'b0, v_d} < V_SYN_E));
            timing_d.end_of_line  = (h_d == H_LAST);
            timing_d.end_of_frame = (h_d == H_LAST) && (v_d == V_LAST);
            fetch_start_d         = (h_d == H_LAST) && ({1'b0, nxt_v_s} < V_VIS);
            if (fetch_start_d) fetch_line_d = nxt_v_s;
            else               fetch_line_d = fetch_line_q;
        end else begin
            timing_d      = TIMING_IDLE;
            fetch_start_d = 1'b0;
            fetch_line_d  = fetch_line_q;
        end
    end

    // State, counters and all registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            h_q           <= 10'd0;
            v_q           <= 10'd0;
            timing_q      <= TIMING_IDLE;
            fetch_start_q <= 1'b0;
            fetch_line_q  <= 10'd0;
        end else begin
            state_q       <= state_d;
            h_q           <= h_d;
            v_q           <= v_d;
            timing_q      <= timing_d;
            fetch_start_q <= fetch_start_d;
            fetch_line_q  <= fetch_line_d;
        end
    end

    assign timing_o      = timing_q;
    assign x_o           = h_q;
    assign y_o           = v_q;
    assign fetch_start_o = fetch_start_q;
    assign fetch_line_o  = fetch_line_q;

`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    // Count completed frames; leaving RUN discards the count.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (state_d == ST_IDLE) begin
            frame_cnt_d = 16'd0;
        end else if (timing_q.end_of_frame) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
    end

    // Frame counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            frame_cnt_q <= 16'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt_o = frame_cnt_q;
`endif

endmodule
